// File: rtl/mem_arb_ctrl_if.sv
// ============================================================================
// Module   : mem_arb_ctrl_if
// Brief    : Accessor-side bus bundle for mem_arb_ctrl (flattened per-accessor lanes).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_arb_ctrl_if #(
    parameter int BITSIZE     = 32,
    parameter int ADDR_W      = 32,
    parameter int N_ACCESSORS = 2
);
    logic [N_ACCESSORS*ADDR_W-1:0]  acc_address_i;
    logic [N_ACCESSORS-1:0]         acc_store_i;
    logic [N_ACCESSORS-1:0]         acc_load_i;
    logic [N_ACCESSORS*BITSIZE-1:0] acc_wdata_i;
    logic [N_ACCESSORS*BITSIZE-1:0] acc_rdata_o;
    logic [N_ACCESSORS-1:0]         acc_ready_o;
    logic [N_ACCESSORS-1:0]         acc_done_o;

    modport master (
        output acc_address_i, acc_store_i, acc_load_i, acc_wdata_i,
        input  acc_rdata_o, acc_ready_o, acc_done_o
    );

    modport slave (
        input  acc_address_i, acc_store_i, acc_load_i, acc_wdata_i,
        output acc_rdata_o, acc_ready_o, acc_done_o
    );
endinterface

`default_nettype wire

// File: rtl/mem_arb_ctrl.sv
// ============================================================================
// Module   : mem_arb_ctrl
// Brief    : N-accessor round-robin arbiter onto one word-addressed memory with
//            programmable access latency. Define MEM_ARB_FIXED_PRIO_EN for
//            fixed lowest-index-wins priority instead of round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arb_ctrl #(
    parameter int BITSIZE     = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_SIZE    = 16,
    parameter int N_ACCESSORS = 2,
    parameter int LATENCY     = 1
) (
    input  wire logic     clk,
    input  wire logic     reset_i,
    mem_arb_ctrl_if.slave bus
);
    localparam int c_IDX_W = $clog2(MEM_SIZE);
    localparam int c_GNT_W = (N_ACCESSORS > 1) ? $clog2(N_ACCESSORS) : 1;
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [c_GNT_W-1:0]                   r_rr_ptr;
    logic [c_GNT_W-1:0]                   r_gnt;
    logic [c_GNT_W-1:0]                   w_gnt;
    logic                                 w_any_req;
    logic [N_ACCESSORS-1:0]               w_req;
    logic                                 r_is_store;
    logic [c_IDX_W-1:0]                   r_idx;
    logic [BITSIZE-1:0]                   r_wdata;
    logic [c_CNT_W-1:0]                   r_cnt;
    logic [BITSIZE-1:0]                   r_mem [MEM_SIZE];
    logic [N_ACCESSORS-1:0][BITSIZE-1:0]  r_rdata;
    logic                                 w_commit;
    logic                                 w_unused;

    assign w_req    = bus.acc_load_i | bus.acc_store_i;
    assign w_commit = (r_state == S_ACCESS) && (r_cnt == '0);
    assign bus.acc_rdata_o = r_rdata;
    // Only the low index bits of each address select a word; the rest wrap.
    assign w_unused = ^bus.acc_address_i;

    // First requester at or after the pointer; a pointer pinned at 0 gives fixed priority.
    always_comb begin : p_grant
        int slot;
        w_gnt     = '0;
        w_any_req = 1'b0;
        slot      = 0;
        for (int k = 0; k < N_ACCESSORS; k++) begin
            slot = int'(r_rr_ptr) + k;
            if (slot >= N_ACCESSORS) begin
                slot = slot - N_ACCESSORS;
            end
            if (!w_any_req && w_req[slot]) begin
                w_any_req = 1'b1;
                w_gnt     = c_GNT_W'(slot);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.acc_ready_o = '0;
        bus.acc_done_o  = '0;
        case (r_state)
            S_IDLE: begin
                bus.acc_ready_o = '1;
                if (w_any_req) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.acc_done_o[r_gnt] = 1'b1;
                w_state_nxt           = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_is_store <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt      <= w_gnt;
                        r_is_store <= bus.acc_store_i[w_gnt];
                        r_idx      <= bus.acc_address_i[int'(w_gnt)*ADDR_W +: c_IDX_W];
                        r_wdata    <= bus.acc_wdata_i[int'(w_gnt)*BITSIZE +: BITSIZE];
                        r_cnt      <= c_CNT_INIT;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_is_store) begin
                        r_rdata[r_gnt] <= r_mem[r_idx];
                    end
                end
                S_DONE: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    r_rr_ptr <= '0;
`else
                    if (int'(r_gnt) == N_ACCESSORS - 1) begin
                        r_rr_ptr <= '0;
                    end else begin
                        r_rr_ptr <= r_gnt + 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Memory has no reset; reset only suppresses an in-flight commit.
    always_ff @(posedge clk) begin
        if (!reset_i && w_commit && r_is_store) begin
            r_mem[r_idx] <= r_wdata;
        end
    end
endmodule

`default_nettype wire
